// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional perf counters are controlled by the HAZ_PERF_EN macro.
package hazard_pkg;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_DIV  = 2'd1,
      S_MISS = 2'd2
   } haz_state_t;

   // The reason the pipe is being held during the current cycle.
   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_LU   = 2'd1,
      CAUSE_DIV  = 2'd2,
      CAUSE_MISS = 2'd3
   } haz_cause_t;

   localparam int DIV_MAX_CYC_DEF = 64;
   localparam int LU_EX_BUB_DEF   = 2;
   localparam int LU_MEM_BUB_DEF  = 1;
   localparam int PERF_W_DEF      = 32;

   localparam int NUM_SRC  = 4;
   localparam int NUM_PROD = 4;
   // Producer slots are ordered EX_a, EX_b, MEM_a, MEM_b.
   localparam int PROD_EX_A  = 0;
   localparam int PROD_EX_B  = 1;
   localparam int PROD_MEM_A = 2;
   localparam int PROD_MEM_B = 3;

   function automatic logic [1:0] bub_max(input logic [1:0] x, input logic [1:0] y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/haz_src_match.sv
// Compares one ID source register against every in-flight producer and
// returns the number of bubbles that source needs.
module haz_src_match
   import hazard_pkg::*;
#(
   parameter int LU_EX_BUB  = LU_EX_BUB_DEF,
   parameter int LU_MEM_BUB = LU_MEM_BUB_DEF
) (
   input  logic [4:0]                raddr,
   input  logic [NUM_PROD-1:0][4:0]  prod_waddr,
   input  logic [NUM_PROD-1:0]       prod_we,
   input  logic [NUM_PROD-1:0]       prod_fwd_ok,
   output logic [1:0]                need
);

   logic [NUM_PROD-1:0][1:0] bub;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PROD; gi++) begin : g_prod
         // Lower half of the producer slots sits in EX, upper half in MEM.
         localparam logic [1:0] BUB = (gi < NUM_PROD / 2) ? 2'(LU_EX_BUB) : 2'(LU_MEM_BUB);
         assign bub[gi] = (raddr != 5'd0 && raddr == prod_waddr[gi] &&
                           prod_we[gi] && !prod_fwd_ok[gi]) ? BUB : 2'd0;
      end
   endgenerate

   always_comb begin
      need = 2'd0;
      for (int i = 0; i < NUM_PROD; i++) begin
         need = bub_max(need, bub[i]);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble scheduler for the dual-issue pipe: load-use, divider hold and
// dcache freeze. Define HAZ_PERF_EN to add saturating per-cause stall counters.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int DIV_MAX_CYC = DIV_MAX_CYC_DEF,
   parameter int LU_EX_BUB   = LU_EX_BUB_DEF,
   parameter int LU_MEM_BUB  = LU_MEM_BUB_DEF,
   parameter int PERF_W      = PERF_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_valid,
   input  logic [4:0]        ID_rf_raddr_a1,
   input  logic [4:0]        ID_rf_raddr_a2,
   input  logic [4:0]        ID_rf_raddr_b1,
   input  logic [4:0]        ID_rf_raddr_b2,
   input  logic [4:0]        EX_rf_waddr_a,
   input  logic [4:0]        EX_rf_waddr_b,
   input  logic              EX_rf_we_a,
   input  logic              EX_rf_we_b,
   input  logic              EX_fwd_ok_a,
   input  logic              EX_fwd_ok_b,
   input  logic [4:0]        MEM_rf_waddr_a,
   input  logic [4:0]        MEM_rf_waddr_b,
   input  logic              MEM_rf_we_a,
   input  logic              MEM_rf_we_b,
   input  logic              MEM_fwd_ok_a,
   input  logic              MEM_fwd_ok_b,
   input  logic              EX_div_req,
   input  logic              div_done,
   input  logic              dcache_busy,
   input  logic              EX_br_flush,
   output logic              IF_stall,
   output logic              ID_stall,
   output logic              EX_stall,
   output logic              MEM_stall,
   output logic              EX_bubble,
   output logic              MEM_bubble,
   output logic              WB_bubble,
   output logic              div_start,
   output logic              div_timeout
`ifdef HAZ_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_lu_cyc,
   output logic [PERF_W-1:0] perf_div_cyc,
   output logic [PERF_W-1:0] perf_miss_cyc
`endif
);

   localparam int DCW = $clog2(DIV_MAX_CYC + 1);

   logic [NUM_PROD-1:0][4:0] prod_waddr;
   logic [NUM_PROD-1:0]      prod_we;
   logic [NUM_PROD-1:0]      prod_fwd_ok;
   logic [NUM_SRC-1:0][4:0]  src_raddr;
   logic [NUM_SRC-1:0][1:0]  src_need;
   logic [1:0]               need;

   assign prod_waddr[PROD_EX_A]  = EX_rf_waddr_a;
   assign prod_waddr[PROD_EX_B]  = EX_rf_waddr_b;
   assign prod_waddr[PROD_MEM_A] = MEM_rf_waddr_a;
   assign prod_waddr[PROD_MEM_B] = MEM_rf_waddr_b;
   assign prod_we     = {MEM_rf_we_b, MEM_rf_we_a, EX_rf_we_b, EX_rf_we_a};
   assign prod_fwd_ok = {MEM_fwd_ok_b, MEM_fwd_ok_a, EX_fwd_ok_b, EX_fwd_ok_a};
   assign src_raddr   = {ID_rf_raddr_b2, ID_rf_raddr_b1, ID_rf_raddr_a2, ID_rf_raddr_a1};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         haz_src_match #(
            .LU_EX_BUB  (LU_EX_BUB),
            .LU_MEM_BUB (LU_MEM_BUB)
         ) u_match (
            .raddr       (src_raddr[gi]),
            .prod_waddr  (prod_waddr),
            .prod_we     (prod_we),
            .prod_fwd_ok (prod_fwd_ok),
            .need        (src_need[gi])
         );
      end
   endgenerate

   always_comb begin
      need = 2'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         need = bub_max(need, src_need[i]);
      end
   end

   haz_state_t       state_reg, state_next;
   logic [1:0]       lu_cnt_reg, lu_cnt_next;
   logic             div_pend_reg, div_pend_next;
   logic             done_q_reg, done_q_next;
   logic [DCW-1:0]   div_cnt_reg, div_cnt_next;
   logic             div_timeout_reg, div_timeout_next;
   haz_cause_t       cause;
   logic             start_c;
   logic             run_cyc;
   logic             run_div_ok;

   always_comb begin
      state_next       = state_reg;
      lu_cnt_next      = lu_cnt_reg;
      div_pend_next    = div_pend_reg;
      done_q_next      = done_q_reg;
      div_cnt_next     = div_cnt_reg;
      div_timeout_next = div_timeout_reg;
      cause            = CAUSE_NONE;
      start_c          = 1'b0;
      run_cyc          = 1'b0;
      run_div_ok       = 1'b1;

      case (state_reg)
         S_RUN: run_cyc = 1'b1;
         S_DIV: begin
            if (dcache_busy) begin
               cause       = CAUSE_MISS;
               state_next  = S_MISS;
               done_q_next = div_done;
            end else if (div_done) begin
               state_next    = S_RUN;
               div_pend_next = 1'b0;
            end else begin
               cause = CAUSE_DIV;
               if (div_cnt_reg != DCW'(DIV_MAX_CYC)) begin
                  div_cnt_next = div_cnt_reg + 1'b1;
                  if (div_cnt_next == DCW'(DIV_MAX_CYC)) begin
                     div_timeout_next = 1'b1;
                  end
               end
            end
         end
         S_MISS: begin
            if (dcache_busy) begin
               cause = CAUSE_MISS;
               if (div_done) begin
                  done_q_next = 1'b1;
               end
            end else if (div_pend_reg && !done_q_reg && !div_done) begin
               cause      = CAUSE_DIV;
               state_next = S_DIV;
            end else begin
               // Exit cycle behaves as a run cycle; a finished divide still sits
               // in EX, so its request must not relaunch the divider.
               run_cyc    = 1'b1;
               state_next = S_RUN;
               if (div_pend_reg) begin
                  run_div_ok    = 1'b0;
                  div_pend_next = 1'b0;
                  done_q_next   = 1'b0;
               end
            end
         end
         default: state_next = S_RUN;
      endcase

      if (run_cyc) begin
         if (dcache_busy) begin
            cause      = CAUSE_MISS;
            state_next = S_MISS;
         end else if (EX_div_req && run_div_ok) begin
            cause         = CAUSE_DIV;
            start_c       = 1'b1;
            state_next    = S_DIV;
            div_pend_next = 1'b1;
            done_q_next   = 1'b0;
            div_cnt_next  = '0;
         end else if (EX_br_flush) begin
            lu_cnt_next = 2'd0;
         end else if (lu_cnt_reg != 2'd0) begin
            cause       = CAUSE_LU;
            lu_cnt_next = lu_cnt_reg - 2'd1;
         end else if (ID_valid && need != 2'd0) begin
            cause       = CAUSE_LU;
            lu_cnt_next = need - 2'd1;
         end
      end

      if (rst) begin
         cause   = CAUSE_NONE;
         start_c = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= S_RUN;
         lu_cnt_reg      <= 2'd0;
         div_pend_reg    <= 1'b0;
         done_q_reg      <= 1'b0;
         div_cnt_reg     <= '0;
         div_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lu_cnt_reg      <= lu_cnt_next;
         div_pend_reg    <= div_pend_next;
         done_q_reg      <= done_q_next;
         div_cnt_reg     <= div_cnt_next;
         div_timeout_reg <= div_timeout_next;
      end
   end

   assign IF_stall    = (cause != CAUSE_NONE);
   assign ID_stall    = (cause != CAUSE_NONE);
   assign EX_stall    = (cause == CAUSE_DIV) || (cause == CAUSE_MISS);
   assign MEM_stall   = (cause == CAUSE_MISS);
   assign EX_bubble   = (cause == CAUSE_LU);
   assign MEM_bubble  = (cause == CAUSE_DIV);
   assign WB_bubble   = (cause == CAUSE_MISS);
   assign div_start   = start_c;
   assign div_timeout = div_timeout_reg;

`ifdef HAZ_PERF_EN
   logic [PERF_W-1:0] perf_lu_reg, perf_div_reg, perf_miss_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_lu_reg   <= '0;
         perf_div_reg  <= '0;
         perf_miss_reg <= '0;
      end else begin
         if (cause == CAUSE_LU && perf_lu_reg != '1) begin
            perf_lu_reg <= perf_lu_reg + 1'b1;
         end
         if (cause == CAUSE_DIV && perf_div_reg != '1) begin
            perf_div_reg <= perf_div_reg + 1'b1;
         end
         if (cause == CAUSE_MISS && perf_miss_reg != '1) begin
            perf_miss_reg <= perf_miss_reg + 1'b1;
         end
      end
   end

   assign perf_lu_cyc   = perf_lu_reg;
   assign perf_div_cyc  = perf_div_reg;
   assign perf_miss_cyc = perf_miss_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-count
// model of the stall rules.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_valid;
   logic [4:0] ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2;
   logic [4:0] EX_rf_waddr_a, EX_rf_waddr_b, MEM_rf_waddr_a, MEM_rf_waddr_b;
   logic       EX_rf_we_a, EX_rf_we_b, EX_fwd_ok_a, EX_fwd_ok_b;
   logic       MEM_rf_we_a, MEM_rf_we_b, MEM_fwd_ok_a, MEM_fwd_ok_b;
   logic       EX_div_req, div_done, dcache_busy, EX_br_flush;
   logic       IF_stall, ID_stall, EX_stall, MEM_stall;
   logic       EX_bubble, MEM_bubble, WB_bubble, div_start, div_timeout;
`ifdef HAZ_PERF_EN
   logic [31:0] perf_lu_cyc, perf_div_cyc, perf_miss_cyc;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // {IF,ID,EX,MEM stall, EX,MEM,WB bubble, div_start, div_timeout}
   localparam logic [8:0] P_NONE = 9'b000000000;
   localparam logic [8:0] P_LU   = 9'b110010000;
   localparam logic [8:0] P_DIV  = 9'b111001000;
   localparam logic [8:0] P_MISS = 9'b111100100;
   localparam logic [8:0] B_START = 9'b000000010;
   localparam logic [8:0] B_TMO   = 9'b000000001;

   logic [8:0] outs;
   assign outs = {IF_stall, ID_stall, EX_stall, MEM_stall, EX_bubble,
                  MEM_bubble, WB_bubble, div_start, div_timeout};

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ID_valid       (ID_valid),
      .ID_rf_raddr_a1 (ID_rf_raddr_a1),
      .ID_rf_raddr_a2 (ID_rf_raddr_a2),
      .ID_rf_raddr_b1 (ID_rf_raddr_b1),
      .ID_rf_raddr_b2 (ID_rf_raddr_b2),
      .EX_rf_waddr_a  (EX_rf_waddr_a),
      .EX_rf_waddr_b  (EX_rf_waddr_b),
      .EX_rf_we_a     (EX_rf_we_a),
      .EX_rf_we_b     (EX_rf_we_b),
      .EX_fwd_ok_a    (EX_fwd_ok_a),
      .EX_fwd_ok_b    (EX_fwd_ok_b),
      .MEM_rf_waddr_a (MEM_rf_waddr_a),
      .MEM_rf_waddr_b (MEM_rf_waddr_b),
      .MEM_rf_we_a    (MEM_rf_we_a),
      .MEM_rf_we_b    (MEM_rf_we_b),
      .MEM_fwd_ok_a   (MEM_fwd_ok_a),
      .MEM_fwd_ok_b   (MEM_fwd_ok_b),
      .EX_div_req     (EX_div_req),
      .div_done       (div_done),
      .dcache_busy    (dcache_busy),
      .EX_br_flush    (EX_br_flush),
      .IF_stall       (IF_stall),
      .ID_stall       (ID_stall),
      .EX_stall       (EX_stall),
      .MEM_stall      (MEM_stall),
      .EX_bubble      (EX_bubble),
      .MEM_bubble     (MEM_bubble),
      .WB_bubble      (WB_bubble),
      .div_start      (div_start),
      .div_timeout    (div_timeout)
`ifdef HAZ_PERF_EN
      ,
      .perf_lu_cyc    (perf_lu_cyc),
      .perf_div_cyc   (perf_div_cyc),
      .perf_miss_cyc  (perf_miss_cyc)
`endif
   );

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs are applied just after a rising edge; outputs are sampled at the
   // following falling edge, then time advances to just past the next rise.
   task automatic step_chk(input string tag, input logic [8:0] exp);
      @(negedge clk);
      chk(tag, outs, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ID_valid = 0; EX_div_req = 0; div_done = 0; dcache_busy = 0; EX_br_flush = 0;
      ID_rf_raddr_a1 = 0; ID_rf_raddr_a2 = 0; ID_rf_raddr_b1 = 0; ID_rf_raddr_b2 = 0;
      EX_rf_waddr_a = 0; EX_rf_waddr_b = 0; MEM_rf_waddr_a = 0; MEM_rf_waddr_b = 0;
      EX_rf_we_a = 0; EX_rf_we_b = 0; EX_fwd_ok_a = 0; EX_fwd_ok_b = 0;
      MEM_rf_we_a = 0; MEM_rf_we_b = 0; MEM_fwd_ok_a = 0; MEM_fwd_ok_b = 0;
   endtask

   // Model state for random trials: sources and producers (0,1 = EX a/b; 2,3 = MEM a/b).
   logic [4:0] m_src [4];
   logic [4:0] m_wa  [4];
   logic       m_we  [4];
   logic       m_fw  [4];

   function automatic int model_need(input logic valid, input logic flush);
      int n = 0;
      if (!valid || flush) return 0;
      for (int s = 0; s < 4; s++) begin
         for (int p = 0; p < 4; p++) begin
            if (m_src[s] != 0 && m_src[s] == m_wa[p] && m_we[p] && !m_fw[p]) begin
               n = (p < 2) ? ((n > 2) ? n : 2) : ((n > 1) ? n : 1);
            end
         end
      end
      return n;
   endfunction

   initial begin
      int need;
      // Reset with busy/div inputs active: every output must stay low.
      idle();
      rst = 1; dcache_busy = 1; EX_div_req = 1; ID_valid = 1;
      @(negedge clk);
      chk("reset_outs", outs, P_NONE);
      @(posedge clk); #1;
      idle(); rst = 0;
      step_chk("post_reset", P_NONE);

      // Load-use on EX lane b: two stall cycles as the producer drains.
      ID_valid = 1; ID_rf_raddr_a1 = 5; EX_rf_waddr_b = 5; EX_rf_we_b = 1;
      step_chk("lu_ex_c0", P_LU);
      EX_rf_we_b = 0; MEM_rf_waddr_b = 5; MEM_rf_we_b = 1;
      step_chk("lu_ex_c1", P_LU);
      MEM_rf_we_b = 0;
      step_chk("lu_ex_c2", P_NONE);

      // Load-use on MEM lane a: one cycle; forwardable result: none.
      idle(); ID_valid = 1; ID_rf_raddr_b2 = 7; MEM_rf_waddr_a = 7; MEM_rf_we_a = 1;
      step_chk("lu_mem_c0", P_LU);
      MEM_rf_we_a = 0;
      step_chk("lu_mem_c1", P_NONE);
      MEM_rf_we_a = 1; MEM_fwd_ok_a = 1;
      step_chk("lu_mem_fwd", P_NONE);

      // r0 never creates a hazard.
      idle(); ID_valid = 1; EX_rf_we_a = 1;
      step_chk("r0_no_stall", P_NONE);

      // Divide completing at cycle 10.
      idle(); EX_div_req = 1;
      step_chk("div_c0", P_DIV | B_START);
      for (int c = 1; c < 10; c++) step_chk("div_hold", P_DIV);
      div_done = 1;
      step_chk("div_done_c10", P_NONE);
      idle();
      step_chk("div_after", P_NONE);

      // Divide interrupted by a miss in cycles 3-6, done at cycle 5.
      EX_div_req = 1;
      step_chk("dm_c0", P_DIV | B_START);
      step_chk("dm_c1", P_DIV);
      step_chk("dm_c2", P_DIV);
      dcache_busy = 1;
      step_chk("dm_c3", P_MISS);
      step_chk("dm_c4", P_MISS);
      div_done = 1;
      step_chk("dm_c5", P_MISS);
      div_done = 0;
      step_chk("dm_c6", P_MISS);
      dcache_busy = 0;
      step_chk("dm_c7_exit", P_NONE);
      EX_div_req = 0;
      step_chk("dm_c8", P_NONE);

      // Miss during divide with no completion returns to the divide wait.
      EX_div_req = 1;
      step_chk("dm2_c0", P_DIV | B_START);
      dcache_busy = 1;
      step_chk("dm2_c1", P_MISS);
      step_chk("dm2_c2", P_MISS);
      dcache_busy = 0;
      step_chk("dm2_c3", P_DIV);
      step_chk("dm2_c4", P_DIV);
      div_done = 1;
      step_chk("dm2_c5", P_NONE);
      idle();

      // Branch flush with one load-use bubble still owed.
      ID_valid = 1; ID_rf_raddr_a2 = 9; EX_rf_waddr_a = 9; EX_rf_we_a = 1;
      step_chk("flush_c0", P_LU);
      EX_rf_we_a = 0; EX_br_flush = 1;
      step_chk("flush_c1", P_NONE);
      EX_br_flush = 0;
      step_chk("flush_c2", P_NONE);
      idle();

      // Watchdog: timeout after 64 cycles spent waiting in the divide state.
      EX_div_req = 1;
      step_chk("tmo_c0", P_DIV | B_START);
      for (int c = 1; c <= 66; c++) begin
         step_chk("tmo_wait", ((c - 1) >= 64) ? (P_DIV | B_TMO) : P_DIV);
      end
      div_done = 1;
      step_chk("tmo_done", B_TMO);
      idle();
      step_chk("tmo_sticky", B_TMO);

      // Reset in the middle of a divide wait.
      EX_div_req = 1;
      step_chk("rstdiv_c0", P_DIV | B_START | B_TMO);
      step_chk("rstdiv_c1", P_DIV | B_TMO);
      rst = 1;
      @(negedge clk);
      chk("rst_in_div", outs, P_NONE);
      @(posedge clk); #1;
      idle(); rst = 0;
      step_chk("rst_release", P_NONE);

      // Randomized load-use trials against the bubble-count model.
      for (int t = 0; t < 40; t++) begin
         idle();
         ID_valid    = ($urandom_range(0, 7) != 0);
         EX_br_flush = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < 4; i++) begin
            m_src[i] = 5'($urandom_range(0, 7));
            m_wa[i]  = 5'($urandom_range(0, 7));
            m_we[i]  = 1'($urandom_range(0, 1));
            m_fw[i]  = ($urandom_range(0, 3) == 0);
         end
         ID_rf_raddr_a1 = m_src[0]; ID_rf_raddr_a2 = m_src[1];
         ID_rf_raddr_b1 = m_src[2]; ID_rf_raddr_b2 = m_src[3];
         EX_rf_waddr_a = m_wa[0]; EX_rf_we_a = m_we[0]; EX_fwd_ok_a = m_fw[0];
         EX_rf_waddr_b = m_wa[1]; EX_rf_we_b = m_we[1]; EX_fwd_ok_b = m_fw[1];
         MEM_rf_waddr_a = m_wa[2]; MEM_rf_we_a = m_we[2]; MEM_fwd_ok_a = m_fw[2];
         MEM_rf_waddr_b = m_wa[3]; MEM_rf_we_b = m_we[3]; MEM_fwd_ok_b = m_fw[3];
         need = model_need(ID_valid, EX_br_flush);
         $display("[TB] trial %0d valid=%0d flush=%0d need=%0d", t, ID_valid, EX_br_flush, need);
         step_chk("rand_c0", (need > 0) ? P_LU : P_NONE);
         EX_rf_we_a = 0; EX_rf_we_b = 0; MEM_rf_we_a = 0; MEM_rf_we_b = 0; EX_br_flush = 0;
         step_chk("rand_c1", (need > 1) ? P_LU : P_NONE);
         step_chk("rand_c2", (need > 2) ? P_LU : P_NONE);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
